bsg_arb_rr_packet_lock: RTL and testbench

//  Round-robin arbiter that shares one downstream beat channel among
//  els_p requesters and holds the grant for a whole multi-beat packet.
//  A requester keeps the channel from its first beat until its last

---
 rtl/bsg_arb_rr_packet_lock_if.sv | 27 ++
 rtl/bsg_arb_rr_packet_lock.sv | 126 ++++++++++++
 tb/tb_bsg_arb_rr_packet_lock.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_arb_rr_packet_lock_if.sv
// Beat-channel bundle between els_p requesters and the packet-locking arbiter.
// The master side drives requests, last flags and downstream ready; the slave side is the arbiter.
interface bsg_arb_rr_packet_lock_if #(
    parameter int els_p = 4
);
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic [els_p-1:0]     reqs_i;
    logic [els_p-1:0]     last_i;
    logic                 ready_i;
    logic [els_p-1:0]     grants_o;
    logic                 v_o;
    logic [lg_els_lp-1:0] sel_id_o;
    logic                 locked_o;
    logic [lg_els_lp-1:0] owner_o;
    logic                 timeout_o;

    modport master (
        output reqs_i, last_i, ready_i,
        input  grants_o, v_o, sel_id_o, locked_o, owner_o, timeout_o
    );

    modport slave (
        input  reqs_i, last_i, ready_i,
        output grants_o, v_o, sel_id_o, locked_o, owner_o, timeout_o
    );
endinterface

// File: rtl/bsg_arb_rr_packet_lock.sv
// Round-robin arbiter that keeps the grant for a whole multi-beat packet.
// A watchdog frees the channel when the owner stays silent mid-packet for too long.
module bsg_arb_rr_packet_lock #(
    parameter int els_p          = 4,
    parameter int hold_timeout_p = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    bsg_arb_rr_packet_lock_if.slave    link
);
    localparam int lg_els_lp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int stall_w_lp  = (hold_timeout_p + 1 > 1) ? $clog2(hold_timeout_p + 1) : 1;
    localparam logic [lg_els_lp-1:0]  last_id_lp   = lg_els_lp'(els_p - 1);
    localparam logic [stall_w_lp-1:0] stall_max_lp = stall_w_lp'(hold_timeout_p - 1);

    typedef enum logic {
        e_idle,
        e_locked
    } state_e;

    state_e                state_r;
    logic [lg_els_lp-1:0]  ptr_r;
    logic [lg_els_lp-1:0]  owner_r;
    logic [stall_w_lp-1:0] stall_r;

    logic [lg_els_lp-1:0]  winner;
    logic [lg_els_lp-1:0]  cand;
    logic                  found;
    logic [lg_els_lp-1:0]  sel;
    logic                  xfer;
    logic                  xfer_last;
    logic                  owner_req;
    logic                  stall_expired;

    // Wrap against els_p-1 rather than relying on overflow, so non-power-of-2 counts work.
    function automatic logic [lg_els_lp-1:0] wrap_inc(input logic [lg_els_lp-1:0] id);
        return (id == last_id_lp) ? '0 : id + lg_els_lp'(1);
    endfunction

    // NOTE: every always_comb output gets a default before any conditional so no latch is inferred.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < els_p; i++) begin
            cand = lg_els_lp'((int'(ptr_r) + i) % els_p);
            if (!found && link.reqs_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        owner_req     = link.reqs_i[owner_r];
        stall_expired = (state_r == e_locked) && !owner_req && (stall_r == stall_max_lp);
        if (state_r == e_idle) begin
            sel  = winner;
            xfer = found && link.ready_i && reset_n_i;
        end else begin
            sel  = owner_r;
            xfer = owner_req && link.ready_i && reset_n_i;
        end
        xfer_last = link.last_i[sel];
    end

    assign link.grants_o  = xfer ? (els_p'(1) << sel) : '0;
    assign link.v_o       = xfer;
    assign link.sel_id_o  = xfer ? sel : '0;
    assign link.locked_o  = (state_r == e_locked);
    assign link.owner_o   = (state_r == e_locked) ? owner_r : '0;
    assign link.timeout_o = reset_n_i && stall_expired;

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            ptr_r   <= '0;
            owner_r <= '0;
            stall_r <= '0;
        end else begin
            case (state_r)
                e_idle: begin
                    if (xfer) begin
                        if (xfer_last) begin
                            ptr_r <= wrap_inc(winner);
                        end else begin
                            state_r <= e_locked;
                            owner_r <= winner;
                            stall_r <= '0;
                        end
                    end
                end
                e_locked: begin
                    if (xfer) begin
                        stall_r <= '0;
                        if (xfer_last) begin
                            state_r <= e_idle;
                            ptr_r   <= wrap_inc(owner_r);
                        end
                    end else if (!owner_req) begin
                        if (stall_r == stall_max_lp) begin
                            state_r <= e_idle;
                            ptr_r   <= wrap_inc(owner_r);
                            stall_r <= '0;
                        end else begin
                            stall_r <= stall_r + stall_w_lp'(1);
                        end
                    end
                    // Owner requesting into a stalled downstream is not an owner stall: count holds.
                end
                default: state_r <= e_idle;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert ($onehot0(link.grants_o));
            assert ((link.grants_o & ~link.reqs_i) == '0);
            assert (link.ready_i || (link.grants_o == '0));
        end
    end
`endif
endmodule

// File: tb/tb_bsg_arb_rr_packet_lock.sv
// Bench for bsg_arb_rr_packet_lock: directed scenarios plus randomized traffic
// compared every cycle against a behavioural arbitration model.
module tb_bsg_arb_rr_packet_lock;
    localparam int N    = 4;
    localparam int HOLD = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    bit   check_en = 1'b0;

    bsg_arb_rr_packet_lock_if #(.els_p(N)) bus ();

    bsg_arb_rr_packet_lock #(
        .els_p          (N),
        .hold_timeout_p (HOLD)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .link      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge; return at the falling edge.
    task automatic cyc(input logic rn, input logic [N-1:0] r, input logic [N-1:0] l, input logic rd);
        @(posedge clk);
        #1;
        rst_n       = rn;
        bus.reqs_i  = r;
        bus.last_i  = l;
        bus.ready_i = rd;
        @(negedge clk);
    endtask

    // Behavioural model: who owns the channel, where the scan starts, and how many
    // silent owner cycles have accumulated since the owner's last accepted beat.
    bit          m_locked = 1'b0;
    int          m_owner  = 0;
    int          m_ptr    = 0;
    int          m_silent = 0;
    logic [N-1:0] eg;
    logic        eto;
    int          e_sel, e_owner, w, c, ended;
    bit          e_locked, was_unlocked;
    int          wait_pkts[N];
    int          open_owner = -1;

    always @(negedge clk) begin
        if (check_en) begin
            e_locked     = m_locked;
            e_owner      = m_locked ? m_owner : 0;
            eg           = '0;
            eto          = 1'b0;
            e_sel        = 0;
            ended        = -1;
            was_unlocked = !m_locked;
            if (!rst_n) begin
                m_locked = 1'b0;
                m_ptr    = 0;
                m_owner  = 0;
                m_silent = 0;
            end else if (!m_locked) begin
                w = -1;
                for (int i = 0; i < N; i++) begin
                    c = (m_ptr + i) % N;
                    if (w < 0 && bus.reqs_i[c]) w = c;
                end
                if (w >= 0 && bus.ready_i) begin
                    eg[w] = 1'b1;
                    e_sel = w;
                    if (bus.last_i[w]) begin
                        m_ptr = (w + 1) % N;
                        ended = w;
                    end else begin
                        m_locked = 1'b1;
                        m_owner  = w;
                        m_silent = 0;
                    end
                end
            end else if (bus.reqs_i[m_owner]) begin
                if (bus.ready_i) begin
                    eg[m_owner] = 1'b1;
                    e_sel       = m_owner;
                    m_silent    = 0;
                    if (bus.last_i[m_owner]) begin
                        m_locked = 1'b0;
                        m_ptr    = (m_owner + 1) % N;
                        ended    = m_owner;
                    end
                end
            end else begin
                m_silent++;
                if (m_silent == HOLD) begin
                    eto      = 1'b1;
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                    ended    = m_owner;
                    m_silent = 0;
                end
            end

            check("grants", 32'(bus.grants_o), 32'(eg));
            check("v", 32'(bus.v_o), 32'(|eg));
            check("sel_id", 32'(bus.sel_id_o), 32'(e_sel));
            check("timeout", 32'(bus.timeout_o), 32'(eto));
            check("locked", 32'(bus.locked_o), 32'(e_locked));
            check("owner", 32'(bus.owner_o), 32'(e_owner));

            // Fairness: a waiting requester sees at most N other packets finish before it wins.
            for (int k = 0; k < N; k++)
                if (!rst_n || !bus.reqs_i[k]) wait_pkts[k] = 0;
            if (|eg && was_unlocked) begin
                check("rr_wait_bound", 32'(wait_pkts[e_sel] <= N), 32'd1);
                wait_pkts[e_sel] = 0;
            end
            if (ended >= 0)
                for (int k = 0; k < N; k++)
                    if (k != ended && bus.reqs_i[k]) wait_pkts[k]++;

            // Packet contiguity observed purely from the DUT's own transfers.
            if (!rst_n || bus.timeout_o) begin
                open_owner = -1;
            end else if (bus.v_o) begin
                if (open_owner >= 0) check("contiguous", 32'(bus.sel_id_o), 32'(open_owner));
                open_owner = bus.last_i[bus.sel_id_o] ? -1 : int'(bus.sel_id_o);
            end
        end
    end

    logic [N-1:0] r, l, g_prev;
    logic         rn;

    initial begin
        rst_n       = 1'b0;
        bus.reqs_i  = '0;
        bus.last_i  = '0;
        bus.ready_i = 1'b1;

        // Reset
        cyc(0, 4'b0000, 4'b0000, 1);
        check_en = 1'b1;
        cyc(0, 4'b1111, 4'b1111, 1);
        check("rst_grants", 32'(bus.grants_o), 32'd0);
        check("rst_v", 32'(bus.v_o), 32'd0);

        // Single-beat packets rotate 0,1,2,3,0,...
        for (int i = 0; i < 8; i++) begin
            cyc(1, 4'b1111, 4'b1111, 1);
            check("t1_sel", 32'(bus.sel_id_o), 32'(i % 4));
            check("t1_locked", 32'(bus.locked_o), 32'd0);
        end

        // Requester 1 sends a 3-beat packet while everyone requests
        cyc(1, 4'b0001, 4'b0001, 1);
        check("t2_pre_sel", 32'(bus.sel_id_o), 32'd0);
        cyc(1, 4'b1111, 4'b1101, 1);
        check("t2_b1_sel", 32'(bus.sel_id_o), 32'd1);
        check("t2_b1_locked", 32'(bus.locked_o), 32'd0);
        cyc(1, 4'b1111, 4'b1101, 1);
        check("t2_b2_sel", 32'(bus.sel_id_o), 32'd1);
        check("t2_b2_locked", 32'(bus.locked_o), 32'd1);
        cyc(1, 4'b1111, 4'b1111, 1);
        check("t2_b3_sel", 32'(bus.sel_id_o), 32'd1);
        check("t2_b3_locked", 32'(bus.locked_o), 32'd1);
        cyc(1, 4'b1111, 4'b1111, 1);
        check("t2_next_sel", 32'(bus.sel_id_o), 32'd2);
        check("t2_next_locked", 32'(bus.locked_o), 32'd0);

        // Owner 2 behind a long downstream stall: no grant, no timeout
        cyc(1, 4'b0100, 4'b0000, 1);
        check("t3_lock_sel", 32'(bus.sel_id_o), 32'd2);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 4'b1111, 4'b0000, 0);
            check("t3_stall_grants", 32'(bus.grants_o), 32'd0);
            check("t3_stall_timeout", 32'(bus.timeout_o), 32'd0);
        end
        cyc(1, 4'b1111, 4'b0000, 1);
        check("t3_resume_grants", 32'(bus.grants_o), 32'b0100);
        cyc(1, 4'b1111, 4'b0100, 1);
        check("t3_last_grants", 32'(bus.grants_o), 32'b0100);

        // Owner 0 goes silent; watchdog fires on the 4th silent cycle, then 3 wins
        cyc(1, 4'b0001, 4'b0000, 1);
        check("t4_lock_sel", 32'(bus.sel_id_o), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 4'b1000, 4'b1000, 1);
            check("t4_silent_grants", 32'(bus.grants_o), 32'd0);
            check("t4_timeout", 32'(bus.timeout_o), 32'(i == 4));
        end
        cyc(1, 4'b1000, 4'b1000, 1);
        check("t4_after_grants", 32'(bus.grants_o), 32'b1000);
        check("t4_after_timeout", 32'(bus.timeout_o), 32'd0);

        // Reset pulse while owner 2 holds the lock
        cyc(1, 4'b0100, 4'b0000, 1);
        check("t5_lock_sel", 32'(bus.sel_id_o), 32'd2);
        cyc(0, 4'b0101, 4'b0000, 1);
        check("t5_rst_grants", 32'(bus.grants_o), 32'd0);
        check("t5_rst_timeout", 32'(bus.timeout_o), 32'd0);
        cyc(1, 4'b0101, 4'b0001, 1);
        check("t5_post_grants", 32'(bus.grants_o), 32'b0001);
        check("t5_post_locked", 32'(bus.locked_o), 32'd0);

        // Randomized traffic; requesters hold each beat until it is granted
        r      = bus.reqs_i;
        l      = bus.last_i;
        g_prev = bus.grants_o;
        for (int n = 0; n < 10000; n++) begin
            for (int k = 0; k < N; k++) begin
                if (g_prev[k]) begin
                    r[k] = 1'b0;
                    if ($urandom_range(3) != 0) begin
                        r[k] = 1'b1;
                        l[k] = ($urandom_range(2) == 0);
                    end
                end else if (!r[k] && $urandom_range(3) == 0) begin
                    r[k] = 1'b1;
                    l[k] = ($urandom_range(2) == 0);
                end
            end
            rn = ($urandom_range(599) != 0);
            cyc(rn, r, l, $urandom_range(3) != 0);
            g_prev = bus.grants_o;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
